// File: rtl/commit_trace_buffer.sv
// Commit trace FIFO: buffers the core's retire stream and drains it through a valid/ready port.
// Optional TRACE_SEQ_EN macro adds a per-commit sequence number (trace_seq_o) that exposes drop gaps.
module commit_trace_buffer #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       commit_valid_i,
  input  logic [XLEN-1:0]            commit_pc_i,
  input  logic [31:0]                commit_instr_i,
  input  logic [4:0]                 commit_rd_i,
  input  logic [XLEN-1:0]            commit_data_i,
  output logic                       trace_valid_o,
  input  logic                       trace_ready_i,
  output logic [XLEN-1:0]            trace_pc_o,
  output logic [31:0]                trace_instr_o,
  output logic [4:0]                 trace_rd_o,
  output logic [XLEN-1:0]            trace_data_o,
`ifdef TRACE_SEQ_EN
  output logic [31:0]                trace_seq_o,
`endif
  output logic                       stall_o,
  output logic                       overflow_o,
  output logic [15:0]                drop_cnt_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_LVL = CW'(AFULL_THRESH);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // x0 writes are architecturally discarded, so they are traced as no-write with zero data
  function automatic logic [XLEN-1:0] mask_x0(input logic [4:0] rd, input logic [XLEN-1:0] data);
    return (rd == 5'd0) ? '0 : data;
  endfunction

  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic [31:0]     mem_instr [DEPTH];
  logic [4:0]      mem_rd    [DEPTH];
  logic [XLEN-1:0] mem_data  [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [15:0]   drop_cnt;
  logic          overflow;
  logic          full;
  logic          push;
  logic          pop;
  logic          drop;

  assign full          = (count == FULL_LVL);
  assign trace_valid_o = (count != '0);
  assign pop           = trace_valid_o && trace_ready_i;
  assign push          = commit_valid_i && (!full || pop);
  assign drop          = commit_valid_i && full && !pop;

  assign stall_o    = (count >= STALL_LVL);
  assign overflow_o = overflow;
  assign drop_cnt_o = drop_cnt;
  assign count_o    = count;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop) begin
        drop_cnt <= sat_inc16(drop_cnt);
        overflow <= 1'b1;
      end
    end
  end

  // Storage carries no reset; validity is tracked solely by count and the pointers
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_pc[wr_ptr]    <= commit_pc_i;
      mem_instr[wr_ptr] <= commit_instr_i;
      mem_rd[wr_ptr]    <= commit_rd_i;
      mem_data[wr_ptr]  <= mask_x0(commit_rd_i, commit_data_i);
    end
  end

  assign trace_pc_o    = mem_pc[rd_ptr];
  assign trace_instr_o = mem_instr[rd_ptr];
  assign trace_rd_o    = mem_rd[rd_ptr];
  assign trace_data_o  = mem_data[rd_ptr];

`ifdef TRACE_SEQ_EN
  // Sequence advances on every retire, accepted or dropped, so sinks can spot lost commits
  logic [31:0] seq_cnt;
  logic [31:0] mem_seq [DEPTH];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) seq_cnt <= '0;
    else if (commit_valid_i) seq_cnt <= seq_cnt + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_seq[wr_ptr] <= seq_cnt;
  end

  assign trace_seq_o = mem_seq[rd_ptr];
`endif

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer against a queue-based reference model.
module tb_commit_trace_buffer;
  localparam int XLEN  = 32;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        commit_valid_i;
  logic [31:0] commit_pc_i;
  logic [31:0] commit_instr_i;
  logic [4:0]  commit_rd_i;
  logic [31:0] commit_data_i;
  logic        trace_valid_o;
  logic        trace_ready_i;
  logic [31:0] trace_pc_o;
  logic [31:0] trace_instr_o;
  logic [4:0]  trace_rd_o;
  logic [31:0] trace_data_o;
`ifdef TRACE_SEQ_EN
  logic [31:0] trace_seq_o;
`endif
  logic        stall_o;
  logic        overflow_o;
  logic [15:0] drop_cnt_o;
  logic [4:0]  count_o;

  always #5 clk = ~clk;

  commit_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .AFULL_THRESH(DEPTH-2)) dut (
    .clk_i          (clk),
    .rstn_i         (rstn_i),
    .commit_valid_i (commit_valid_i),
    .commit_pc_i    (commit_pc_i),
    .commit_instr_i (commit_instr_i),
    .commit_rd_i    (commit_rd_i),
    .commit_data_i  (commit_data_i),
    .trace_valid_o  (trace_valid_o),
    .trace_ready_i  (trace_ready_i),
    .trace_pc_o     (trace_pc_o),
    .trace_instr_o  (trace_instr_o),
    .trace_rd_o     (trace_rd_o),
    .trace_data_o   (trace_data_o),
`ifdef TRACE_SEQ_EN
    .trace_seq_o    (trace_seq_o),
`endif
    .stall_o        (stall_o),
    .overflow_o     (overflow_o),
    .drop_cnt_o     (drop_cnt_o),
    .count_o        (count_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] seq;
  } ent_t;

  ent_t        q[$];
  int unsigned m_drops;
  bit          m_ovf;
  logic [31:0] m_seq;
  int          checks = 0;
  int          errors = 0;

  task automatic model_clear();
    q.delete();
    m_drops = 0;
    m_ovf   = 1'b0;
    m_seq   = '0;
  endtask

  // One clock: drive at the falling edge, advance the model at the rising edge, return 1ns later
  task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] instr,
                      input logic [4:0] rd, input logic [31:0] data, input bit rdy);
    ent_t e;
    bit   do_pop;
    bit   do_push;
    @(negedge clk);
    commit_valid_i = v;
    commit_pc_i    = pc;
    commit_instr_i = instr;
    commit_rd_i    = rd;
    commit_data_i  = data;
    trace_ready_i  = rdy;
    @(posedge clk);
    do_pop  = (q.size() != 0) && rdy;
    do_push = v && ((q.size() < DEPTH) || do_pop);
    e.pc    = pc;
    e.instr = instr;
    e.rd    = rd;
    e.data  = (rd == 5'd0) ? 32'd0 : data;
    e.seq   = m_seq;
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(e);
    else if (v) begin
      if (m_drops < 65535) m_drops++;
      m_ovf = 1'b1;
    end
    if (v) m_seq = m_seq + 32'd1;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    commit_valid_i = 1'b0;
    trace_ready_i  = 1'b0;
    rstn_i = 1'b0;
    @(negedge clk);
    rstn_i = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    commit_valid_i = 1'b0;
    commit_pc_i = '0; commit_instr_i = '0; commit_rd_i = '0; commit_data_i = '0;
    trace_ready_i = 1'b0;
    model_clear();
    #1;
    checks++; if (trace_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", trace_valid_o); end
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow_o); end
    checks++; if (drop_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt_o); end
    @(negedge clk);
    rstn_i = 1'b1;
    step(1'b0, '0, '0, '0, '0, 1'b1);
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL idle_count got=%0d exp=0", count_o); end
  endtask

  task automatic test_basic_fwft();
    step(1'b1, 32'h0000_0000, 32'h0050_0093, 5'd1, 32'h5, 1'b1);
    checks++; if (trace_valid_o !== 1'b1) begin errors++; $display("FAIL fwft_valid got=%b exp=1", trace_valid_o); end
    checks++; if (trace_pc_o !== 32'h0) begin errors++; $display("FAIL fwft_pc got=%h exp=00000000", trace_pc_o); end
    checks++; if (trace_instr_o !== 32'h0050_0093) begin errors++; $display("FAIL fwft_instr got=%h exp=00500093", trace_instr_o); end
    checks++; if (trace_rd_o !== 5'd1) begin errors++; $display("FAIL fwft_rd got=%0d exp=1", trace_rd_o); end
    checks++; if (trace_data_o !== 32'h5) begin errors++; $display("FAIL fwft_data got=%h exp=00000005", trace_data_o); end
    checks++; if (count_o !== 5'd1) begin errors++; $display("FAIL fwft_count1 got=%0d exp=1", count_o); end
    step(1'b0, '0, '0, '0, '0, 1'b1);
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL fwft_count0 got=%0d exp=0", count_o); end
    checks++; if (trace_valid_o !== 1'b0) begin errors++; $display("FAIL fwft_valid0 got=%b exp=0", trace_valid_o); end
  endtask

  task automatic test_x0_mask();
    step(1'b1, 32'h0000_0100, 32'h0000_0013, 5'd0, 32'hDEAD_BEEF, 1'b0);
    checks++; if (trace_rd_o !== 5'd0) begin errors++; $display("FAIL x0_rd got=%0d exp=0", trace_rd_o); end
    checks++; if (trace_data_o !== 32'h0) begin errors++; $display("FAIL x0_data got=%h exp=00000000", trace_data_o); end
    step(1'b0, '0, '0, '0, '0, 1'b1);
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL x0_count got=%0d exp=0", count_o); end
  endtask

  task automatic test_fill_overflow();
    int occ;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 32'h1000 + 32'(4*i), 32'h13 + 32'(i << 7), 5'((i % 31) + 1), 32'(i * 3), 1'b0);
      occ = (i + 1 < 16) ? i + 1 : 16;
      checks++; if (count_o !== 5'(occ)) begin errors++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count_o, occ); end
      checks++; if (stall_o !== (occ >= 14)) begin errors++; $display("FAIL fill_stall[%0d] got=%b exp=%b", i, stall_o, occ >= 14); end
    end
    checks++; if (drop_cnt_o !== 16'd4) begin errors++; $display("FAIL fill_drop got=%0d exp=4", drop_cnt_o); end
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL fill_overflow got=%b exp=1", overflow_o); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (trace_valid_o !== 1'b1 || trace_pc_o !== 32'h1000 + 32'(4*i) || trace_data_o !== 32'(i * 3)) begin
        errors++; $display("FAIL drain_head[%0d] got v=%b pc=%h data=%h exp v=1 pc=%h data=%h",
                           i, trace_valid_o, trace_pc_o, trace_data_o, 32'h1000 + 32'(4*i), 32'(i * 3));
      end
      step(1'b0, '0, '0, '0, '0, 1'b1);
    end
    checks++; if (count_o !== 5'd0 || trace_valid_o !== 1'b0) begin errors++; $display("FAIL drain_empty got cnt=%0d v=%b exp cnt=0 v=0", count_o, trace_valid_o); end
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL overflow_sticky got=%b exp=1", overflow_o); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 16; i++)
      step(1'b1, 32'h2000 + 32'(4*i), 32'h33, 5'd2, 32'(i), 1'b0);
    checks++; if (count_o !== 5'd16) begin errors++; $display("FAIL pp_fill got=%0d exp=16", count_o); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (trace_pc_o !== 32'h2000 + 32'(4*i)) begin errors++; $display("FAIL pp_head[%0d] got=%h exp=%h", i, trace_pc_o, 32'h2000 + 32'(4*i)); end
      step(1'b1, 32'h3000 + 32'(4*i), 32'h33, 5'd2, 32'(100 + i), 1'b1);
      checks++; if (count_o !== 5'd16) begin errors++; $display("FAIL pp_count[%0d] got=%0d exp=16", i, count_o); end
    end
    checks++; if (drop_cnt_o !== 16'd4) begin errors++; $display("FAIL pp_drop got=%0d exp=4", drop_cnt_o); end
    for (int i = 0; i < 9; i++) begin
      checks++; if (trace_pc_o !== q[0].pc || trace_data_o !== q[0].data) begin
        errors++; $display("FAIL pp_drain[%0d] got pc=%h data=%h exp pc=%h data=%h", i, trace_pc_o, trace_data_o, q[0].pc, q[0].data);
      end
      step(1'b0, '0, '0, '0, '0, 1'b1);
    end
    checks++; if (count_o !== 5'd7) begin errors++; $display("FAIL pp_left got=%0d exp=7", count_o); end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    commit_valid_i = 1'b0;
    trace_ready_i  = 1'b0;
    #1 rstn_i = 1'b0;
    #1;
    checks++; if (trace_valid_o !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", trace_valid_o); end
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL mid_count got=%0d exp=0", count_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL mid_overflow got=%b exp=0", overflow_o); end
    checks++; if (drop_cnt_o !== 16'd0) begin errors++; $display("FAIL mid_drop got=%0d exp=0", drop_cnt_o); end
    #1 rstn_i = 1'b1;
    model_clear();
    step(1'b1, 32'h0000_ABC0, 32'h0070_0113, 5'd3, 32'h77, 1'b0);
    step(1'b0, '0, '0, '0, '0, 1'b0);
    checks++; if (count_o !== 5'd1 || trace_pc_o !== 32'h0000_ABC0 || trace_data_o !== 32'h77) begin
      errors++; $display("FAIL mid_alone got cnt=%0d pc=%h data=%h exp cnt=1 pc=0000abc0 data=00000077", count_o, trace_pc_o, trace_data_o);
    end
    step(1'b0, '0, '0, '0, '0, 1'b1);
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL mid_pop got=%0d exp=0", count_o); end
  endtask

  task automatic test_random();
    bit          v;
    bit          r;
    logic [4:0]  rd;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(0, 9) < 8);
      r  = ($urandom_range(0, 9) < ((i < 200) ? 4 : 8));
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      step(v, $urandom, $urandom, rd, $urandom, r);
      checks++; if (count_o !== 5'(q.size())) begin errors++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", i, count_o, q.size()); end
      checks++; if (trace_valid_o !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, trace_valid_o, q.size() != 0); end
      checks++; if (stall_o !== (q.size() >= DEPTH - 2)) begin errors++; $display("FAIL rnd_stall[%0d] got=%b", i, stall_o); end
      checks++; if (drop_cnt_o !== 16'(m_drops) || overflow_o !== m_ovf) begin
        errors++; $display("FAIL rnd_drop[%0d] got=%0d/%b exp=%0d/%b", i, drop_cnt_o, overflow_o, m_drops, m_ovf);
      end
      if (q.size() != 0) begin
        checks++;
        if (trace_pc_o !== q[0].pc || trace_instr_o !== q[0].instr || trace_rd_o !== q[0].rd || trace_data_o !== q[0].data) begin
          errors++; $display("FAIL rnd_head[%0d] got %h %h %0d %h exp %h %h %0d %h", i, trace_pc_o, trace_instr_o,
                             trace_rd_o, trace_data_o, q[0].pc, q[0].instr, q[0].rd, q[0].data);
        end
`ifdef TRACE_SEQ_EN
        checks++; if (trace_seq_o !== q[0].seq) begin errors++; $display("FAIL rnd_seq[%0d] got=%0d exp=%0d", i, trace_seq_o, q[0].seq); end
`endif
      end
    end
  endtask

`ifdef TRACE_SEQ_EN
  task automatic test_trace_seq();
    do_reset();
    for (int i = 0; i < 18; i++)
      step(1'b1, 32'h4000 + 32'(4*i), 32'h13, 5'd4, 32'(i), 1'b0);
    for (int i = 0; i < 16; i++) begin
      checks++; if (trace_seq_o !== 32'(i)) begin errors++; $display("FAIL seq_drain[%0d] got=%0d exp=%0d", i, trace_seq_o, i); end
      step(1'b0, '0, '0, '0, '0, 1'b1);
    end
    step(1'b1, 32'h5000, 32'h13, 5'd4, 32'h1, 1'b0);
    checks++; if (trace_seq_o !== 32'd18) begin errors++; $display("FAIL seq_gap got=%0d exp=18", trace_seq_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_fwft();
    test_x0_mask();
    test_fill_overflow();
    test_full_push_pop();
    test_reset_midstream();
    test_random();
`ifdef TRACE_SEQ_EN
    test_trace_seq();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
